// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester and memory-controller signals around the SDRAM arbiter.
interface sdram_arbiter_if;
    logic        req_0, we_0, ack_0, rvalid_0;
    logic        req_1, we_1, ack_1, rvalid_1;
    logic [22:0] addr_0, addr_1, mem_addr;
    logic [7:0]  wdata_0, wdata_1, rdata_0, rdata_1, mem_din, mem_dout;
    logic        mem_rd, mem_wr, mem_refresh, mem_data_ready, mem_busy, refresh_miss;
    modport slave (
        input  req_0, we_0, addr_0, wdata_0, req_1, we_1, addr_1, wdata_1,
        input  mem_dout, mem_data_ready, mem_busy,
        output ack_0, rdata_0, rvalid_0, ack_1, rdata_1, rvalid_1,
        output mem_rd, mem_wr, mem_refresh, mem_addr, mem_din, refresh_miss
    );
    modport master (
        output req_0, we_0, addr_0, wdata_0, req_1, we_1, addr_1, wdata_1,
        output mem_dout, mem_data_ready, mem_busy,
        input  ack_0, rdata_0, rvalid_0, ack_1, rdata_1, rvalid_1,
        input  mem_rd, mem_wr, mem_refresh, mem_addr, mem_din, refresh_miss
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter with periodic refresh in front of a byte-wide SDRAM controller.
module sdram_arbiter #(
    parameter int FREQ       = 27_000_000,
    parameter int REFRESH_US = 15
) (
    input  logic           clk,
    input  logic           resetn,
    sdram_arbiter_if.slave bus
);
    localparam int REFRESH_CYCLES = FREQ / 1_000_000 * REFRESH_US;
    localparam int CW = $clog2(REFRESH_CYCLES);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [22:0]   addr_q, addr_d;
    logic [7:0]    din_q, din_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          rd_q, rd_d, wr_q, wr_d, refr_q, refr_d, ack0_q, ack0_d, ack1_q, ack1_d, rv0_q, rv0_d, rv1_q, rv1_d;
    logic          pend_q, pend_d, miss_q, miss_d, last_q, last_d, read_q, read_d, first_q, first_d, got_q, got_d, live_q;
    logic          tc, go, acc, pick, we, cap, done;
    always_comb begin
        tc   = cnt_q == CW'(REFRESH_CYCLES - 1);
        pick = (bus.req_0 && bus.req_1) ? !last_q : bus.req_1;
        we   = pick ? bus.we_1 : bus.we_0;
        go   = state_q == IDLE && live_q && !bus.mem_busy && (pend_q || bus.req_0 || bus.req_1);
        acc  = go && !pend_q;
        cap  = state_q == WAIT && read_q && !got_q && bus.mem_data_ready;
        done = !first_q && !bus.mem_busy && (!read_q || got_q || bus.mem_data_ready);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            default: state_d = done ? IDLE : WAIT;
        endcase
        // the controller raises busy a cycle late, so the first WAIT cycle is not trusted
        first_d  = state_q == ISSUE;
        got_d    = state_q == WAIT && (got_q || cap);
        read_d   = go ? acc && !we : read_q;
        rd_d     = acc && !we;
        wr_d     = acc && we;
        refr_d   = go && pend_q;
        ack0_d   = acc && !pick;
        ack1_d   = acc && pick;
        rv0_d    = cap && !last_q;
        rv1_d    = cap && last_q;
        rdata0_d = rv0_d ? bus.mem_dout : rdata0_q;
        rdata1_d = rv1_d ? bus.mem_dout : rdata1_q;
        addr_d   = acc ? (pick ? bus.addr_1 : bus.addr_0) : addr_q;
        din_d    = acc ? (pick ? bus.wdata_1 : bus.wdata_0) : din_q;
        last_d   = acc ? pick : last_q;
        cnt_d    = tc ? '0 : cnt_q + 1'b1;
        pend_d   = tc || (pend_q && !refr_d);
        miss_d   = miss_q || (tc && pend_q);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            {rd_q, wr_q, refr_q, ack0_q, ack1_q, rv0_q, rv1_q} <= '0;
            {pend_q, miss_q, read_q, first_q, got_q, live_q} <= '0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            {rd_q, wr_q, refr_q, ack0_q, ack1_q, rv0_q, rv1_q} <= {rd_d, wr_d, refr_d, ack0_d, ack1_d, rv0_d, rv1_d};
            {pend_q, miss_q, read_q, first_q, got_q} <= {pend_d, miss_d, read_d, first_d, got_d};
            last_q   <= last_d;
            live_q   <= 1'b1;
        end
    end
    assign bus.mem_rd       = rd_q;
    assign bus.mem_wr       = wr_q;
    assign bus.mem_refresh  = refr_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_din      = din_q;
    assign bus.ack_0        = ack0_q;
    assign bus.ack_1        = ack1_q;
    assign bus.rvalid_0     = rv0_q;
    assign bus.rvalid_1     = rv1_q;
    assign bus.rdata_0      = rdata0_q;
    assign bus.rdata_1      = rdata1_q;
    assign bus.refresh_miss = miss_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized checks of the SDRAM arbiter against a memory/arbitration reference model.
module tb_sdram_arbiter;
    localparam int R = 405;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;
    sdram_arbiter_if bus();
    sdram_arbiter dut (.clk(clk), .resetn(resetn), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;
    bit m_last = 1'b1;
    logic        treq [2];
    logic        twe  [2];
    logic [22:0] tad  [2];
    logic [7:0]  twd  [2];
    logic [7:0]  ref_mem [logic [22:0]];
    logic [7:0]  cmem [logic [22:0]];
    assign bus.req_0 = treq[0];
    assign bus.we_0 = twe[0];
    assign bus.addr_0 = tad[0];
    assign bus.wdata_0 = twd[0];
    assign bus.req_1 = treq[1];
    assign bus.we_1 = twe[1];
    assign bus.addr_1 = tad[1];
    assign bus.wdata_1 = twd[1];

    // controller model: 3 busy cycles per command, read data 3 cycles after the command is seen
    logic hold_busy = 1'b0;
    int busy_cnt = 0;
    int rd_cnt = 0;
    logic [22:0] rd_addr = '0;
    logic rdy = 1'b0;
    logic [7:0] dout = '0;
    assign bus.mem_busy = hold_busy || busy_cnt != 0;
    assign bus.mem_data_ready = rdy;
    assign bus.mem_dout = dout;
    always @(posedge clk) begin
        rdy <= 1'b0;
        if (rd_cnt == 1) begin
            rdy <= 1'b1;
            dout <= cmem.exists(rd_addr) ? cmem[rd_addr] : 8'h00;
        end
        if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (bus.mem_wr) begin
            cmem[bus.mem_addr] = bus.mem_din;
            busy_cnt <= 3;
        end
        if (bus.mem_rd) begin
            rd_addr <= bus.mem_addr;
            rd_cnt <= 3;
            busy_cnt <= 3;
        end
        if (bus.mem_refresh) busy_cnt <= 3;
    end

    function automatic logic [7:0] ref_read(input logic [22:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [54:0] outs();
        return {bus.ack_0, bus.ack_1, bus.rvalid_0, bus.rvalid_1, bus.mem_rd, bus.mem_wr, bus.mem_refresh,
                bus.refresh_miss, bus.mem_addr, bus.mem_din, bus.rdata_0, bus.rdata_1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_only();
        resetn = 1'b0;
        treq[0] = 1'b0;
        treq[1] = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        m_last = 1'b1;
    endtask

    task automatic apply_reset();
        reset_only();
        repeat (2) tick();
    endtask

    task automatic settle();
        repeat (2) tick();
        for (int i = 0; i < 50 && bus.mem_busy; i++) tick();
        repeat (2) tick();
    endtask

    // one arbitration round: the model fixes grant order and read data before any stimulus
    task automatic run_round(input logic [1:0] mask);
        int ord [2];
        int n;
        logic [7:0] exp_rd [2];
        bit want_rv [2];
        int acked = 0;
        int seen_rv = 0;
        int n_rv = 0;
        int cyc = 0;
        want_rv[0] = 1'b0;
        want_rv[1] = 1'b0;
        if (mask == 2'b11) begin
            ord[0] = m_last ? 0 : 1;
            ord[1] = 1 - ord[0];
            n = 2;
        end else begin
            ord[0] = int'(mask[1]);
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            if (twe[ord[k]]) ref_mem[tad[ord[k]]] = twd[ord[k]];
            else begin
                exp_rd[ord[k]] = ref_read(tad[ord[k]]);
                want_rv[ord[k]] = 1'b1;
                n_rv++;
            end
        end
        m_last = ord[n-1] != 0;
        treq[0] = mask[0];
        treq[1] = mask[1];
        while ((acked < n || seen_rv < n_rv) && cyc < 100) begin
            tick();
            cyc++;
            if (bus.ack_0 || bus.ack_1) begin
                int p = bus.ack_1 ? 1 : 0;
                n_checks++;
                if (acked >= n || p != ord[acked] || (bus.ack_0 && bus.ack_1)) begin
                    n_fail++;
                    $display("FAIL grant: ack0=%b ack1=%b, expected port %0d", bus.ack_0, bus.ack_1, acked < n ? ord[acked] : -1);
                end
                n_checks++;
                if (bus.mem_addr !== tad[p] || bus.mem_wr !== twe[p] || bus.mem_rd !== !twe[p] || (twe[p] && bus.mem_din !== twd[p])) begin
                    n_fail++;
                    $display("FAIL command: rd=%b wr=%b addr=%h din=%h, expected we=%b addr=%h din=%h",
                             bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_din, twe[p], tad[p], twd[p]);
                end
                if (acked == 0) begin
                    n_checks++;
                    if (cyc != 1) begin
                        n_fail++;
                        $display("FAIL latency: first ack after %0d cycles, expected 1", cyc);
                    end
                end
                treq[p] = 1'b0;
                acked++;
            end else if (bus.mem_rd || bus.mem_wr) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray command: rd=%b wr=%b without ack", bus.mem_rd, bus.mem_wr);
            end
            for (int p = 0; p < 2; p++) begin
                if (p == 1 ? bus.rvalid_1 : bus.rvalid_0) begin
                    logic [7:0] got = p == 1 ? bus.rdata_1 : bus.rdata_0;
                    n_checks++;
                    if (!want_rv[p] || got !== exp_rd[p]) begin
                        n_fail++;
                        $display("FAIL read data port %0d: got %h (expected=%b), required %h", p, got, want_rv[p], exp_rd[p]);
                    end
                    want_rv[p] = 1'b0;
                    seen_rv++;
                end
            end
        end
        n_checks++;
        if (cyc >= 100) begin
            n_fail++;
            $display("FAIL round timeout: acks %0d/%0d, rvalid %0d/%0d", acked, n, seen_rv, n_rv);
        end
        treq[0] = 1'b0;
        treq[1] = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        treq[0] = 1'b1;
        twe[0] = 1'b1;
        tad[0] = 23'h55;
        twd[0] = 8'h3C;
        #1;
        n_checks++;
        if (outs() !== 55'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h, required 0", outs());
        end
        repeat (2) tick();
        resetn = 1'b1;
        m_last = 1'b1;
        tick();
        n_checks++;
        if (bus.ack_0 !== 1'b0 || bus.mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL early issue: ack0=%b wr=%b at first edge, required 0", bus.ack_0, bus.mem_wr);
        end
        tick();
        n_checks++;
        if (bus.ack_0 !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 23'h55 || bus.mem_din !== 8'h3C) begin
            n_fail++;
            $display("FAIL first issue: ack0=%b wr=%b addr=%h din=%h, required 1 1 55 3c", bus.ack_0, bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
        treq[0] = 1'b0;
        ref_mem[23'h55] = 8'h3C;
        m_last = 1'b0;
        settle();
    endtask

    task automatic test_write_read();
        apply_reset();
        twe[0] = 1'b1;
        tad[0] = 23'h1;
        twd[0] = 8'hED;
        run_round(2'b01);
        twe[0] = 1'b0;
        run_round(2'b01);
        n_checks++;
        if (bus.rdata_0 !== 8'hED) begin
            n_fail++;
            $display("FAIL rdata hold: got %h, required ed", bus.rdata_0);
        end
    endtask

    task automatic test_contention();
        int k = 0;
        int cyc = 0;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            twe[p] = 1'b1;
            tad[p] = 23'($urandom_range(0, 23'h7fffff));
            twd[p] = 8'($urandom);
        end
        treq[0] = 1'b1;
        treq[1] = 1'b1;
        while (k < 8 && cyc < 200) begin
            tick();
            cyc++;
            if (bus.ack_0 || bus.ack_1) begin
                int e = k % 2;
                n_checks++;
                if ((bus.ack_1 ? 1 : 0) != e || (bus.ack_0 && bus.ack_1) || bus.mem_addr !== tad[e] || bus.mem_din !== twd[e]) begin
                    n_fail++;
                    $display("FAIL contention grant %0d: ack0=%b ack1=%b addr=%h, required port %0d addr=%h", k, bus.ack_0, bus.ack_1, bus.mem_addr, e, tad[e]);
                end
                ref_mem[tad[e]] = twd[e];
                k++;
            end
        end
        treq[0] = 1'b0;
        treq[1] = 1'b0;
        n_checks++;
        if (k != 8) begin
            n_fail++;
            $display("FAIL contention count: %0d grants, required 8", k);
        end
        m_last = 1'b1;
        settle();
    endtask

    task automatic test_random();
        for (int b = 0; b < 5; b++) begin
            apply_reset();
            for (int r = 0; r < 8; r++) begin
                for (int p = 0; p < 2; p++) begin
                    twe[p] = 1'($urandom_range(0, 1));
                    tad[p] = 23'($urandom_range(0, 7));
                    twd[p] = 8'($urandom);
                end
                run_round(2'($urandom_range(1, 3)));
            end
        end
    endtask

    task automatic test_busy_gating();
        bit early = 1'b0;
        logic [7:0] exp;
        int cyc = 0;
        hold_busy = 1'b1;
        apply_reset();
        twe[1] = 1'b0;
        tad[1] = 23'h3;
        exp = ref_read(23'h3);
        treq[1] = 1'b1;
        repeat (200) begin
            tick();
            if (bus.ack_1 || bus.mem_rd || bus.mem_wr || bus.mem_refresh) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL busy gating: command issued while busy, required none");
        end
        hold_busy = 1'b0;
        tick();
        n_checks++;
        if (bus.ack_1 !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 23'h3) begin
            n_fail++;
            $display("FAIL busy release: ack1=%b rd=%b addr=%h, required 1 1 3", bus.ack_1, bus.mem_rd, bus.mem_addr);
        end
        treq[1] = 1'b0;
        m_last = 1'b1;
        while (bus.rvalid_1 !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (bus.rvalid_1 !== 1'b1 || bus.rdata_1 !== exp) begin
            n_fail++;
            $display("FAIL busy read: rvalid1=%b rdata1=%h, required 1 %h", bus.rvalid_1, bus.rdata_1, exp);
        end
        settle();
    endtask

    task automatic test_reset_mid_read();
        bit bad = 1'b0;
        apply_reset();
        twe[1] = 1'b0;
        tad[1] = 23'h1234;
        treq[1] = 1'b1;
        tick();
        n_checks++;
        if (bus.ack_1 !== 1'b1 || bus.mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL mid-read issue: ack1=%b rd=%b, required 1 1", bus.ack_1, bus.mem_rd);
        end
        treq[1] = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 55'd0) begin
            n_fail++;
            $display("FAIL async reset: outputs %h, required 0", outs());
        end
        repeat (2) tick();
        resetn = 1'b1;
        m_last = 1'b1;
        repeat (20) begin
            tick();
            if (outs() !== 55'd0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL abandoned read: outputs became %h, required 0", outs());
        end
        settle();
    endtask

    task automatic test_refresh();
        int pulses [$];
        bit wide = 1'b0;
        int t_ref = 0;
        int t_ack = 0;
        reset_only();
        for (int t = 1; t <= 1300; t++) begin
            tick();
            if (bus.mem_refresh) begin
                if (pulses.size() > 0 && pulses[$] == t - 1) wide = 1'b1;
                pulses.push_back(t);
            end
        end
        n_checks++;
        if (pulses.size() != 3 || wide) begin
            n_fail++;
            $display("FAIL refresh count: %0d pulses (wide=%b), required 3", pulses.size(), wide);
        end
        for (int i = 0; i < pulses.size() && i < 3; i++) begin
            n_checks++;
            if (pulses[i] != R + 1 + i * R) begin
                n_fail++;
                $display("FAIL refresh period: pulse %0d at cycle %0d, required %0d", i, pulses[i], R + 1 + i * R);
            end
        end
        n_checks++;
        if (bus.refresh_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh miss: got %b, required 0", bus.refresh_miss);
        end
        settle();
        reset_only();
        for (int t = 1; t <= 500 && t_ack == 0; t++) begin
            tick();
            if (bus.mem_refresh && t_ref == 0) t_ref = t;
            if (bus.ack_0) begin
                t_ack = t;
                n_checks++;
                if (bus.mem_wr !== 1'b1 || bus.mem_addr !== tad[0]) begin
                    n_fail++;
                    $display("FAIL post-refresh write: wr=%b addr=%h, required 1 %h", bus.mem_wr, bus.mem_addr, tad[0]);
                end
                treq[0] = 1'b0;
            end
            if (t == 400) begin
                hold_busy = 1'b1;
                twe[0] = 1'b1;
                tad[0] = 23'($urandom_range(0, 7));
                twd[0] = 8'($urandom);
                treq[0] = 1'b1;
            end
            if (t == 410) hold_busy = 1'b0;
        end
        n_checks++;
        if (t_ref != 411 || t_ack <= t_ref) begin
            n_fail++;
            $display("FAIL refresh priority: refresh at %0d, ack0 at %0d, required refresh at 411 before ack0", t_ref, t_ack);
        end
        ref_mem[tad[0]] = twd[0];
        m_last = 1'b0;
        settle();
    endtask

    task automatic test_starvation();
        int pulses [$];
        int first_miss = 0;
        bit dropped = 1'b0;
        hold_busy = 1'b1;
        reset_only();
        for (int t = 1; t <= 1200; t++) begin
            tick();
            if (bus.refresh_miss && first_miss == 0) first_miss = t;
            if (!bus.refresh_miss && first_miss != 0) dropped = 1'b1;
            if (bus.mem_refresh) pulses.push_back(t);
            if (t == 900) hold_busy = 1'b0;
        end
        n_checks++;
        if (first_miss != 2 * R) begin
            n_fail++;
            $display("FAIL miss onset: cycle %0d, required %0d", first_miss, 2 * R);
        end
        n_checks++;
        if (dropped || bus.refresh_miss !== 1'b1) begin
            n_fail++;
            $display("FAIL miss sticky: dropped=%b final=%b, required 0 1", dropped, bus.refresh_miss);
        end
        n_checks++;
        if (pulses.size() != 1 || pulses[0] != 901) begin
            n_fail++;
            $display("FAIL starved refresh: %0d pulses, first at %0d, required 1 at 901", pulses.size(), pulses.size() > 0 ? pulses[0] : -1);
        end
        settle();
    endtask

    initial begin
        treq[0] = 1'b0;
        treq[1] = 1'b0;
        twe[0] = 1'b0;
        twe[1] = 1'b0;
        tad[0] = '0;
        tad[1] = '0;
        twd[0] = '0;
        twd[1] = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_random();
        test_busy_gating();
        test_reset_mid_read();
        test_refresh();
        test_starvation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
